// File: rtl/boruss_pkg.sv
// boruss_pkg: shared state encodings and constants for the boruss prefetch unit.
package boruss_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2,
        STOP    = 2'd3
    } pf_state_e;

    localparam logic [7:0] HALT_OPCODE = 8'hFF;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/boruss_sync_fifo.sv
// boruss_sync_fifo: circular buffer with combinational head read; flush beats push and pop.
module boruss_sync_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 16,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push, do_pop;

    assign do_pop  = pop && level_q != '0;
    assign do_push = push && (level_q != LW'(DEPTH) || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_q + LW'(do_push) - LW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only visible while counted in level.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = level_q != '0 ? mem_q[rd_ptr_q] : '0;
    assign level = level_q;

endmodule

// File: rtl/boruss_prefetch_unit.sv
// boruss_prefetch_unit: fetches instruction bytes over req/ack into a queue and streams them
// to the control FSM; redirects flush and restart, a HALT byte stops fetching.
module boruss_prefetch_unit
    import boruss_pkg::*;
#(
    parameter  int                DEPTH      = 4,
    parameter  int                ADDR_W     = DEF_ADDR_W,
    parameter  int                DATA_W     = DEF_DATA_W,
    parameter  logic [ADDR_W-1:0] RESET_ADDR = '0,
    localparam int                LW         = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              instr_ready,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [LW-1:0]     level,
    output logic              stopped
);

    pf_state_e                state_q, state_d;
    logic [ADDR_W-1:0]        fetch_ptr_q, fetch_ptr_d;
    logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
    logic                     push, pop, is_halt;
    logic [ADDR_W+DATA_W-1:0] head;

    assign is_halt = mem_rdata == DATA_W'(HALT_OPCODE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            fetch_ptr_q <= RESET_ADDR;
            mem_addr_q  <= RESET_ADDR;
        end else begin
            state_q     <= state_d;
            fetch_ptr_q <= fetch_ptr_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    // A redirect always retargets fetch_ptr; an outstanding request still runs to its ack.
    always_comb begin
        state_d     = state_q;
        fetch_ptr_d = redirect ? redirect_addr : fetch_ptr_q;
        mem_addr_d  = mem_addr_q;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!redirect && level < LW'(DEPTH)) begin
                    state_d    = REQ;
                    mem_addr_d = fetch_ptr_q;
                end
            end
            REQ: begin
                if (redirect) begin
                    state_d = mem_ack ? IDLE : DISCARD;
                end else if (mem_ack) begin
                    push        = 1'b1;
                    fetch_ptr_d = fetch_ptr_q + 1'b1;
                    state_d     = is_halt ? STOP : IDLE;
                end
            end
            DISCARD: state_d = mem_ack ? IDLE : DISCARD;
            STOP:    state_d = redirect ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
    end

    assign pop         = instr_valid && instr_ready;
    assign instr_valid = level != '0;
    assign mem_req     = state_q == REQ || state_q == DISCARD;
    assign mem_addr    = mem_addr_q;
    assign stopped     = state_q == STOP;
    assign {instr_addr, instr_data} = head;

    boruss_sync_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(ADDR_W + DATA_W)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .flush(redirect),
        .push (push),
        .pop  (pop),
        .wdata({fetch_ptr_q, mem_rdata}),
        .rdata(head),
        .level(level)
    );

endmodule
